// File: rtl/result_uart_tx.sv
// Sends a latched 32-bit processor result as four 8N1 UART bytes, MSB byte first,
// each byte LSB first. Requests that arrive while a frame is in progress are dropped.
module result_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] result,
  input  logic        result_valid,
  output logic        ready,
  output logic        tx,
  output logic        busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        r_state;
  state_t        w_stateNext;
  logic [31:0]   r_shreg;
  logic [31:0]   w_shregNext;
  logic [1:0]    r_byteIdx;
  logic [1:0]    w_byteIdxNext;
  logic [2:0]    r_bitIdx;
  logic [2:0]    w_bitIdxNext;
  logic [CW-1:0] r_baudCnt;
  logic [CW-1:0] w_baudCntNext;
  logic          w_bitDone;
  logic          w_txNext;

  assign w_bitDone = (r_baudCnt == BAUD_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_byteIdx <= '0;
      r_bitIdx  <= '0;
      r_baudCnt <= '0;
      tx        <= 1'b1;
      ready     <= 1'b1;
      busy      <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_shreg   <= w_shregNext;
      r_byteIdx <= w_byteIdxNext;
      r_bitIdx  <= w_bitIdxNext;
      r_baudCnt <= w_baudCntNext;
      tx        <= w_txNext;
      ready     <= (w_stateNext == IDLE);
      busy      <= (w_stateNext != IDLE);
    end
  end

  // Outputs are derived from the next state so they line up with it after the edge.
  always_comb begin
    w_stateNext   = r_state;
    w_shregNext   = r_shreg;
    w_byteIdxNext = r_byteIdx;
    w_bitIdxNext  = r_bitIdx;
    w_baudCntNext = w_bitDone ? '0 : r_baudCnt + 1'b1;
    w_txNext      = 1'b1;

    unique case (r_state)
      IDLE: begin
        w_baudCntNext = '0;
        if (result_valid && ready) begin
          w_shregNext   = result;
          w_byteIdxNext = '0;
          w_bitIdxNext  = '0;
          w_stateNext   = START;
        end
      end
      START: begin
        if (w_bitDone) w_stateNext = DATA;
      end
      DATA: begin
        if (w_bitDone) begin
          if (r_bitIdx == 3'd7) w_stateNext = STOP;
          else                  w_bitIdxNext = r_bitIdx + 3'd1;
        end
      end
      STOP: begin
        if (w_bitDone) begin
          if (r_byteIdx != 2'd3) begin
            w_byteIdxNext = r_byteIdx + 2'd1;
            w_bitIdxNext  = '0;
            w_stateNext   = START;
          end else begin
            w_stateNext = IDLE;
          end
        end
      end
      default: w_stateNext = IDLE;
    endcase

    // Bit (3-byteIdx)*8+bitIdx walks the bytes from [31:24] down, each LSB first.
    unique case (w_stateNext)
      START:   w_txNext = 1'b0;
      DATA:    w_txNext = w_shregNext[{~w_byteIdxNext, w_bitIdxNext}];
      default: w_txNext = 1'b1;
    endcase
  end

endmodule
